tug_field: RTL

Parametrised tug-of-war playfield: owns the whole row of N lights as one position register instead of N separate per-light state machines. Moves the lit position on player press pulses and detects an edge win. Holds the winning light for a fixed period, then recentres for the next round. Keeps per-player scores and latches game-over at a target score. Sits between the press-conditioning logic (debounced, single-cycle press pulses) and the LED and score display drivers.

---
 rtl/tug_field.sv | 108 ++++++++++
 1 files changed

// File: rtl/tug_field.sv
// Tug-of-war playfield: one position register for the whole light row, round-win
// detection with a fixed hold on the winning light, per-player scores and game-over latch.
module tug_field #(
  parameter int N_LIGHTS    = 9,
  parameter int HOLD_CYCLES = 16,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left_press,
  input  logic                right_press,
  output logic [N_LIGHTS-1:0] lights,
  output logic                left_win,
  output logic                right_win,
  output logic [SCORE_W-1:0]  left_score,
  output logic [SCORE_W-1:0]  right_score,
  output logic                game_over
);

  localparam int PW   = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0]      CENTRE   = PW'((N_LIGHTS - 1) / 2);
  localparam logic [PW-1:0]      EDGE_L   = PW'(N_LIGHTS - 1);
  localparam logic [HC_W-1:0]    HOLD_END = HC_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      pos, pos_n;
  logic [HC_W-1:0]    hold_cnt, hold_n;
  logic [SCORE_W-1:0] ls_n, rs_n;
  logic               lw_n, rw_n, go_n;
  logic               mv_l, mv_r;

  // Simultaneous presses cancel each other out.
  assign mv_l   = left_press & ~right_press;
  assign mv_r   = right_press & ~left_press;
  assign lights = N_LIGHTS'(1) << pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLAY;
      pos         <= CENTRE;
      hold_cnt    <= '0;
      left_score  <= '0;
      right_score <= '0;
      left_win    <= 1'b0;
      right_win   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      hold_cnt    <= hold_n;
      left_score  <= ls_n;
      right_score <= rs_n;
      left_win    <= lw_n;
      right_win   <= rw_n;
      game_over   <= go_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    hold_n  = hold_cnt;
    ls_n    = left_score;
    rs_n    = right_score;
    lw_n    = 1'b0;
    rw_n    = 1'b0;
    case (state)
      PLAY: begin
        if (mv_l) begin
          if (pos == EDGE_L) begin
            ls_n    = left_score + 1'b1;
            lw_n    = 1'b1;
            hold_n  = '0;
            state_n = (ls_n == WIN_VAL) ? DONE : HOLD;
          end else begin
            pos_n = pos + 1'b1;
          end
        end else if (mv_r) begin
          if (pos == '0) begin
            rs_n    = right_score + 1'b1;
            rw_n    = 1'b1;
            hold_n  = '0;
            state_n = (rs_n == WIN_VAL) ? DONE : HOLD;
          end else begin
            pos_n = pos - 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_END) begin
          hold_n  = '0;
          pos_n   = CENTRE;
          state_n = PLAY;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    go_n = (state_n == DONE);
  end

endmodule
